hlen_extract_ctrl: RTL and testbench
====================================

Name: hlen_extract_ctrl

Overview:
- Controller that sequences the 64-bit header-length register on the ingress path.
- Watches the 64-bit packet beat stream leaving the input FIFO and parses the Ethernet/IPv4 header.
- Computes the total header length in bytes and issues a single-cycle write (HLEN_Reg_write_en / HLEN_in) to the HLEN register.
- Holds off the next packet until the downstream consumer acknowledges the current length.

Parameters:
- ETH_HDR_BYTES, 14, Ethernet header length added to the IP header length.
- ETHERTYPE_IPV4, 16'h0800, ethertype accepted as IPv4.
- CNT_W, 16, width of the packet and error counters.

Ports:
- clk  in  1  system clock.
- rst_FIFO  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_sop  in  1  first beat of packet; qualified by in_valid.
- in_eop  in  1  last beat of packet; qualified by in_valid.
- in_data  in  64  beat data; byte 0 at [63:56].
- in_ready  out  1  beat accepted when in_valid && in_ready.
- HLEN_Reg_write_en  out  1  one-cycle write strobe to the HLEN register.
- HLEN_in  out  64  value written to the HLEN register.
- hlen_valid  out  1  a new length is committed and not yet acknowledged.
- hlen_err  out  1  the committed length is an error (value 0); valid only while hlen_valid is high.
- hlen_ack  in  1  consumer acknowledge; clears hlen_valid.
- pkt_count  out  CNT_W  number of commits performed.
- err_count  out  CNT_W  number of error commits performed.

Behaviour:
- Clock and reset: one clock, clk. rst_FIFO is synchronous and active-high.
- Reset: state=IDLE. HLEN_Reg_write_en=0, HLEN_in=0, hlen_valid=0, hlen_err=0, pkt_count=0, err_count=0. Reset wins over every other event, including mid-packet.
- State IDLE:
  - in_ready = !hlen_valid.
  - Accepted beat with in_sop=1 and in_eop=0 -> HDR1.
  - Accepted beat with in_sop=1 and in_eop=1 (runt) -> COMMIT with error.
  - Accepted beat with in_sop=0 (stray beat) -> dropped, remain IDLE, no counters change.
- State HDR1:
  - in_ready=1.
  - Accepted beat: ethertype=in_data[31:16], version=in_data[15:12], IHL=in_data[11:8].
  - Valid iff ethertype==ETHERTYPE_IPV4 && version==4 && IHL>=5.
  - Valid: next HLEN value = ETH_HDR_BYTES + 4*IHL, zero-extended to 64 bits (34..74 at default parameters). Error: next value 0.
  - Next state is COMMIT. The eop flag of this beat is remembered.
  - in_sop on this beat is ignored.
- State COMMIT (exactly one cycle):
  - in_ready=0.
  - HLEN_Reg_write_en=1; HLEN_in presents the computed value.
  - pkt_count+1; err_count+1 on error.
  - Next state: IDLE if the packet already ended (runt, or eop seen in HDR1), else BODY.
- Output timing after commit:
  - HLEN_in is registered and holds its value until the next COMMIT.
  - hlen_valid=1 and hlen_err set from the cycle after COMMIT.
- State BODY:
  - in_ready=1; beats are consumed without inspection.
  - in_sop is ignored.
  - Accepted beat with in_eop=1 -> IDLE.
- hlen_ack:
  - Clears hlen_valid and hlen_err on the next edge.
  - Ack while hlen_valid=0 has no effect.
  - Ack arriving during BODY is legal.
- Latency: HDR1 beat accepted at edge N -> HLEN_Reg_write_en high in cycle N+1 -> hlen_valid high from N+2.
- Backpressure:
  - A new sop is never accepted while hlen_valid=1, so a committed length is never overwritten before ack.
  - The first cycle a new sop can be accepted is the cycle after the hlen_ack edge.
- Counters wrap from 2^CNT_W-1 to 0.
- HLEN_Reg_write_en is never high for two consecutive cycles.

Test Plan:
- Valid IPv4 packet, IHL=5, ethertype 0x0800, 3 beats -> one write strobe with HLEN_in=34, hlen_valid=1 and hlen_err=0 until ack, pkt_count=1, err_count=0.
- IHL=15, eop on beat 1 -> HLEN_in=74, state returns to IDLE directly after COMMIT with no BODY cycles.
- Ethertype 0x86DD, then separately version=6 and IHL=4 -> for each case HLEN_in=0 and hlen_err=1; after the three packets err_count=3 and pkt_count=3.
- Second sop presented while hlen_valid=1 with ack withheld 5 cycles -> in_ready=0 throughout and no write strobe; after the ack edge the sop is accepted and the second commit occurs.
- Runt packet (sop&eop on one beat), plus stray non-sop beats presented in IDLE -> runt gives one error commit with HLEN_in=0; stray beats are dropped and counters do not change.
- rst_FIFO asserted for 1 cycle during BODY with hlen_valid=1 -> all outputs 0 and state IDLE on the next cycle; a fresh valid packet then commits normally with pkt_count=1.

Source files
------------

// File: rtl/hlen_extract_ctrl.sv
// Header-length extraction controller: parses the Ethernet/IPv4 header from the
// ingress beat stream and commits the total header length to the HLEN register.
module hlen_extract_ctrl #(
    parameter int unsigned ETH_HDR_BYTES  = 14,
    parameter logic [15:0] ETHERTYPE_IPV4 = 16'h0800,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_FIFO,
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic [63:0]      in_data,
    output logic             in_ready,
    output logic             HLEN_Reg_write_en,
    output logic [63:0]      HLEN_in,
    output logic             hlen_valid,
    output logic             hlen_err,
    input  logic             hlen_ack,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HDR1   = 2'd1,
        COMMIT = 2'd2,
        BODY   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        load;
    logic [63:0] val_nxt;
    logic        err_nxt;
    logic        eop_nxt;
    logic        eop_p0;
    logic        err_p0;

    // Only the ethertype/version/IHL field of the second beat is inspected.
    logic unused_data;
    assign unused_data = ^{in_data[63:32], in_data[7:0]};

    function automatic logic hdr_ok(input logic [63:0] d);
        return (d[31:16] == ETHERTYPE_IPV4) && (d[15:12] == 4'd4) && (d[11:8] >= 4'd5);
    endfunction

    function automatic logic [63:0] calc_hlen(input logic [63:0] d);
        if (hdr_ok(d))
            return 64'(ETH_HDR_BYTES) + 64'({d[11:8], 2'b00});
        else
            return 64'd0;
    endfunction

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        load      = 1'b0;
        val_nxt   = 64'd0;
        err_nxt   = 1'b0;
        eop_nxt   = eop_p0;
        case (state)
            IDLE: begin
                // A committed length must be acknowledged before a new packet starts.
                in_ready = !hlen_valid;
                if (in_valid && in_ready && in_sop) begin
                    if (in_eop) begin
                        state_nxt = COMMIT;
                        load      = 1'b1;
                        err_nxt   = 1'b1;
                        eop_nxt   = 1'b1;
                    end else begin
                        state_nxt = HDR1;
                    end
                end
            end
            HDR1: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = COMMIT;
                    load      = 1'b1;
                    val_nxt   = calc_hlen(in_data);
                    err_nxt   = !hdr_ok(in_data);
                    eop_nxt   = in_eop;
                end
            end
            COMMIT: begin
                state_nxt = eop_p0 ? IDLE : BODY;
            end
            BODY: begin
                in_ready = 1'b1;
                if (in_valid && in_eop)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: strobe and value registered on entry to COMMIT; status on exit.
    always_ff @(posedge clk) begin
        if (rst_FIFO) begin
            state             <= IDLE;
            HLEN_Reg_write_en <= 1'b0;
            HLEN_in           <= 64'd0;
            hlen_valid        <= 1'b0;
            hlen_err          <= 1'b0;
            pkt_count         <= '0;
            err_count         <= '0;
            eop_p0            <= 1'b0;
            err_p0            <= 1'b0;
        end else begin
            state             <= state_nxt;
            HLEN_Reg_write_en <= load;
            if (load) begin
                HLEN_in <= val_nxt;
                err_p0  <= err_nxt;
                eop_p0  <= eop_nxt;
            end
            if (state == COMMIT) begin
                hlen_valid <= 1'b1;
                hlen_err   <= err_p0;
                pkt_count  <= pkt_count + 1'b1;
                if (err_p0)
                    err_count <= err_count + 1'b1;
            end else if (hlen_ack) begin
                hlen_valid <= 1'b0;
                hlen_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hlen_extract_ctrl.sv
// Directed testbench for hlen_extract_ctrl.
module tb_hlen_extract_ctrl;

    logic        clk = 1'b0;
    logic        rst_FIFO = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sop = 1'b0;
    logic        in_eop = 1'b0;
    logic [63:0] in_data = 64'd0;
    logic        in_ready;
    logic        HLEN_Reg_write_en;
    logic [63:0] HLEN_in;
    logic        hlen_valid;
    logic        hlen_err;
    logic        hlen_ack = 1'b0;
    logic [15:0] pkt_count;
    logic [15:0] err_count;

    int checks = 0;
    int failures = 0;

    hlen_extract_ctrl dut (
        .clk(clk), .rst_FIFO(rst_FIFO), .in_valid(in_valid), .in_sop(in_sop),
        .in_eop(in_eop), .in_data(in_data), .in_ready(in_ready),
        .HLEN_Reg_write_en(HLEN_Reg_write_en), .HLEN_in(HLEN_in),
        .hlen_valid(hlen_valid), .hlen_err(hlen_err), .hlen_ack(hlen_ack),
        .pkt_count(pkt_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] hdr(input logic [15:0] et, input logic [3:0] ver, input logic [3:0] ihl);
        return {32'hA5A5_0000, et, ver, ihl, 8'h3C};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic sop, input logic eop, input logic [63:0] d);
        int n = 0;
        in_valid = 1'b1; in_sop = sop; in_eop = eop; in_data = d;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_ready: in_ready=%0b required 1 within 20 cycles", in_ready);
        end
        tick();
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic do_ack();
        hlen_ack = 1'b1;
        tick();
        hlen_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_FIFO = 1'b1;
        tick(); tick();
        rst_FIFO = 1'b0;
        checks++;
        if ({HLEN_Reg_write_en, hlen_valid, hlen_err} !== 3'b000 || HLEN_in !== 64'd0) begin
            failures++;
            $display("FAIL reset_outputs: we/valid/err=%b hlen=%0d required 000/0",
                     {HLEN_Reg_write_en, hlen_valid, hlen_err}, HLEN_in);
        end
        checks++;
        if (pkt_count !== 16'd0 || err_count !== 16'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_counts: pkt=%0d err=%0d rdy=%b required 0 0 1", pkt_count, err_count, in_ready);
        end
    endtask

    task automatic test_valid_ihl5();
        send(1'b1, 1'b0, 64'hDEAD_BEEF_0000_0001);
        send(1'b0, 1'b0, hdr(16'h0800, 4'd4, 4'd5));
        checks++;
        if (HLEN_Reg_write_en !== 1'b1 || HLEN_in !== 64'd34 || hlen_valid !== 1'b0) begin
            failures++;
            $display("FAIL ihl5_commit: we=%b hlen=%0d valid=%b required 1 34 0", HLEN_Reg_write_en, HLEN_in, hlen_valid);
        end
        tick();
        checks++;
        if (HLEN_Reg_write_en !== 1'b0 || hlen_valid !== 1'b1 || hlen_err !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ihl5_post: we=%b valid=%b err=%b rdy=%b required 0 1 0 1",
                     HLEN_Reg_write_en, hlen_valid, hlen_err, in_ready);
        end
        checks++;
        if (pkt_count !== 16'd1 || err_count !== 16'd0) begin
            failures++;
            $display("FAIL ihl5_counts: pkt=%0d err=%0d required 1 0", pkt_count, err_count);
        end
        send(1'b0, 1'b1, 64'h0123_4567_89AB_CDEF);
        checks++;
        if (in_ready !== 1'b0 || hlen_valid !== 1'b1 || HLEN_in !== 64'd34) begin
            failures++;
            $display("FAIL ihl5_hold: rdy=%b valid=%b hlen=%0d required 0 1 34", in_ready, hlen_valid, HLEN_in);
        end
        do_ack();
        checks++;
        if (hlen_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ihl5_ack: valid=%b rdy=%b required 0 1", hlen_valid, in_ready);
        end
    endtask

    task automatic test_ihl15_short();
        send(1'b1, 1'b0, 64'd0);
        send(1'b0, 1'b1, hdr(16'h0800, 4'd4, 4'd15));
        checks++;
        if (HLEN_Reg_write_en !== 1'b1 || HLEN_in !== 64'd74) begin
            failures++;
            $display("FAIL ihl15_commit: we=%b hlen=%0d required 1 74", HLEN_Reg_write_en, HLEN_in);
        end
        tick();
        checks++;
        if (in_ready !== 1'b0 || hlen_valid !== 1'b1 || pkt_count !== 16'd2) begin
            failures++;
            $display("FAIL ihl15_idle: rdy=%b valid=%b pkt=%0d required 0 1 2", in_ready, hlen_valid, pkt_count);
        end
        do_ack();
    endtask

    task automatic test_errors();
        logic [63:0] bad [3];
        bad[0] = hdr(16'h86DD, 4'd4, 4'd5);
        bad[1] = hdr(16'h0800, 4'd6, 4'd5);
        bad[2] = hdr(16'h0800, 4'd4, 4'd4);
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 1'b0, 64'd0);
            send(1'b0, 1'b1, bad[i]);
            checks++;
            if (HLEN_Reg_write_en !== 1'b1 || HLEN_in !== 64'd0) begin
                failures++;
                $display("FAIL err_commit%0d: we=%b hlen=%0d required 1 0", i, HLEN_Reg_write_en, HLEN_in);
            end
            tick();
            checks++;
            if (hlen_valid !== 1'b1 || hlen_err !== 1'b1) begin
                failures++;
                $display("FAIL err_flag%0d: valid=%b err=%b required 1 1", i, hlen_valid, hlen_err);
            end
            do_ack();
        end
        checks++;
        if (pkt_count !== 16'd5 || err_count !== 16'd3 || hlen_err !== 1'b0) begin
            failures++;
            $display("FAIL err_counts: pkt=%0d err=%0d hlen_err=%b required 5 3 0", pkt_count, err_count, hlen_err);
        end
    endtask

    task automatic test_back_to_back();
        send(1'b1, 1'b0, 64'd0);
        send(1'b0, 1'b1, hdr(16'h0800, 4'd4, 4'd6));
        checks++;
        if (HLEN_in !== 64'd38) begin
            failures++;
            $display("FAIL b2b_first: hlen=%0d required 38", HLEN_in);
        end
        tick();
        in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b0; in_data = 64'd0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (in_ready !== 1'b0 || HLEN_Reg_write_en !== 1'b0) begin
                failures++;
                $display("FAIL b2b_hold%0d: rdy=%b we=%b required 0 0", i, in_ready, HLEN_Reg_write_en);
            end
            tick();
        end
        hlen_ack = 1'b1;
        tick();
        hlen_ack = 1'b0;
        checks++;
        if (hlen_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_release: valid=%b rdy=%b required 0 1", hlen_valid, in_ready);
        end
        tick();
        in_valid = 1'b0; in_sop = 1'b0;
        send(1'b0, 1'b1, hdr(16'h0800, 4'd4, 4'd7));
        checks++;
        if (HLEN_Reg_write_en !== 1'b1 || HLEN_in !== 64'd42) begin
            failures++;
            $display("FAIL b2b_second: we=%b hlen=%0d required 1 42", HLEN_Reg_write_en, HLEN_in);
        end
        tick();
        checks++;
        if (pkt_count !== 16'd7 || HLEN_Reg_write_en !== 1'b0) begin
            failures++;
            $display("FAIL b2b_count: pkt=%0d we=%b required 7 0", pkt_count, HLEN_Reg_write_en);
        end
        do_ack();
    endtask

    task automatic test_runt_stray();
        in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b1; in_data = hdr(16'h0800, 4'd4, 4'd5);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b1 || HLEN_Reg_write_en !== 1'b0) begin
                failures++;
                $display("FAIL stray%0d: rdy=%b we=%b required 1 0", i, in_ready, HLEN_Reg_write_en);
            end
            tick();
        end
        in_valid = 1'b0; in_eop = 1'b0;
        checks++;
        if (pkt_count !== 16'd7 || err_count !== 16'd3 || HLEN_in !== 64'd42 || HLEN_Reg_write_en !== 1'b0) begin
            failures++;
            $display("FAIL stray_counts: pkt=%0d err=%0d hlen=%0d we=%b required 7 3 42 0",
                     pkt_count, err_count, HLEN_in, HLEN_Reg_write_en);
        end
        send(1'b1, 1'b1, 64'hFFFF_FFFF_0800_4500);
        checks++;
        if (HLEN_Reg_write_en !== 1'b1 || HLEN_in !== 64'd0) begin
            failures++;
            $display("FAIL runt_commit: we=%b hlen=%0d required 1 0", HLEN_Reg_write_en, HLEN_in);
        end
        tick();
        checks++;
        if (hlen_err !== 1'b1 || hlen_valid !== 1'b1 || err_count !== 16'd4 || pkt_count !== 16'd8 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL runt_post: err=%b valid=%b errc=%0d pkt=%0d rdy=%b required 1 1 4 8 0",
                     hlen_err, hlen_valid, err_count, pkt_count, in_ready);
        end
        do_ack();
    endtask

    task automatic test_reset_mid_packet();
        send(1'b1, 1'b0, 64'd0);
        send(1'b0, 1'b0, hdr(16'h0800, 4'd4, 4'd5));
        tick();
        checks++;
        if (hlen_valid !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_body: valid=%b rdy=%b required 1 1", hlen_valid, in_ready);
        end
        rst_FIFO = 1'b1;
        tick();
        rst_FIFO = 1'b0;
        checks++;
        if ({HLEN_Reg_write_en, hlen_valid, hlen_err} !== 3'b000 || HLEN_in !== 64'd0 ||
            pkt_count !== 16'd0 || err_count !== 16'd0) begin
            failures++;
            $display("FAIL rstmid_clear: we/valid/err=%b hlen=%0d pkt=%0d err=%0d required 000 0 0 0",
                     {HLEN_Reg_write_en, hlen_valid, hlen_err}, HLEN_in, pkt_count, err_count);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_idle: rdy=%b required 1", in_ready);
        end
        send(1'b1, 1'b0, 64'd0);
        send(1'b0, 1'b1, hdr(16'h0800, 4'd4, 4'd5));
        checks++;
        if (HLEN_Reg_write_en !== 1'b1 || HLEN_in !== 64'd34) begin
            failures++;
            $display("FAIL rstmid_fresh: we=%b hlen=%0d required 1 34", HLEN_Reg_write_en, HLEN_in);
        end
        tick();
        checks++;
        if (pkt_count !== 16'd1 || err_count !== 16'd0 || hlen_valid !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_count: pkt=%0d err=%0d valid=%b required 1 0 1", pkt_count, err_count, hlen_valid);
        end
        do_ack();
    endtask

    initial begin
        tick();
        test_reset();
        test_valid_ihl5();
        test_ihl15_short();
        test_errors();
        test_back_to_back();
        test_runt_stray();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
